// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: opcodes, FSM states, flag masks.
package alu_pkg;

  // Arithmetic and shift opcodes (0xxxx space)
  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_ADDINC = 5'b00001;
  localparam logic [4:0] OP_INCA   = 5'b00011;
  localparam logic [4:0] OP_SUBDEC = 5'b00100;
  localparam logic [4:0] OP_SUB    = 5'b00101;
  localparam logic [4:0] OP_DECA   = 5'b00110;
  localparam logic [4:0] OP_LSL    = 5'b01000;
  localparam logic [4:0] OP_ASR    = 5'b01001;

  // Bitwise opcodes (1xxxx space): low nibble is the truth table, indexed by {a,b}
  localparam logic [4:0] OP_ZEROS    = 5'b10000;
  localparam logic [4:0] OP_NOR      = 5'b10001;
  localparam logic [4:0] OP_ANDNOTA  = 5'b10010;
  localparam logic [4:0] OP_PASSNOTA = 5'b10011;
  localparam logic [4:0] OP_ANDNOTB  = 5'b10100;
  localparam logic [4:0] OP_PASSNOTB = 5'b10101;
  localparam logic [4:0] OP_XOR      = 5'b10110;
  localparam logic [4:0] OP_NAND     = 5'b10111;
  localparam logic [4:0] OP_AND      = 5'b11000;
  localparam logic [4:0] OP_XNOR     = 5'b11001;
  localparam logic [4:0] OP_PASSB    = 5'b11010;
  localparam logic [4:0] OP_ORNOTA   = 5'b11011;
  localparam logic [4:0] OP_PASSA    = 5'b11100;
  localparam logic [4:0] OP_ORNOTB   = 5'b11101;
  localparam logic [4:0] OP_OR       = 5'b11110;
  localparam logic [4:0] OP_ONES     = 5'b11111;

  // Flag register layout {O,S,C,Z}
  localparam logic [3:0] MASK_OSCZ = 4'b1111;
  localparam logic [3:0] MASK_SCZ  = 4'b0111;
  localparam logic [3:0] MASK_SZ   = 4'b0101;
  localparam logic [3:0] MASK_Z    = 4'b0001;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Which flag bits an opcode is allowed to update; undefined opcodes update none
  function automatic logic [3:0] flag_mask(input logic [4:0] op);
    logic [3:0] m;
    m = MASK_NONE;
    case (op)
      OP_ADD, OP_ADDINC, OP_INCA,
      OP_SUBDEC, OP_SUB, OP_DECA:              m = MASK_OSCZ;
      OP_LSL, OP_ASR:                          m = MASK_SCZ;
      OP_ZEROS:                                m = MASK_Z;
      OP_AND, OP_ANDNOTA, OP_ANDNOTB, OP_PASSA,
      OP_XOR, OP_OR, OP_NAND, OP_XNOR,
      OP_PASSNOTA, OP_ORNOTA, OP_PASSNOTB,
      OP_ORNOTB, OP_NOR:                       m = MASK_SZ;
      default:                                 m = MASK_NONE;
    endcase
    return m;
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_LSL) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub family, single-bit shifts, 16 bitwise functions.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v,
  output logic             err
);

  logic [WIDTH-1:0] y;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;
  logic [3:0]       tt;

  // All arithmetic ops share one adder as a + y + cin; C is the adder carry-out
  always_comb begin
    y     = '0;
    cin   = 1'b0;
    arith = 1'b1;
    case (op)
      OP_ADD:    begin y = b;  cin = 1'b0; end
      OP_ADDINC: begin y = b;  cin = 1'b1; end
      OP_INCA:   begin y = '0; cin = 1'b1; end
      OP_SUBDEC: begin y = ~b; cin = 1'b0; end
      OP_SUB:    begin y = ~b; cin = 1'b1; end
      OP_DECA:   begin y = '1; cin = 1'b0; end
      default:   arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign tt  = op[3:0];

  // Result select; shifts move one bit per call, the controller iterates
  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    if (arith) begin
      res = sum[WIDTH-1:0];
      c   = sum[WIDTH];
      v   = (a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (op == OP_LSL) begin
      res = {a[WIDTH-2:0], 1'b0};
      c   = a[WIDTH-1];
    end else if (op == OP_ASR) begin
      res = {a[WIDTH-1], a[WIDTH-1:1]};
      c   = a[0];
    end else if (op[4]) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        res[i] = tt[{a[i], b[i]}];
      end
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Request/response ALU controller with iterative shifts and a persistent flag register.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [4:0]       REQ_OP,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  input  logic [4:0]       REQ_SHAMT,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_RES,
  output logic             RSP_ERR,
  output logic [3:0]       FLAGS,
  output logic             BUSY
);

  state_t           state;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       cnt;
  logic             noop_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic [3:0]       fmask;
  logic [3:0]       fnew;

  alu #(.WIDTH(WIDTH)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res),
    .c   (alu_c),
    .v   (alu_v),
    .err (alu_err)
  );

  assign fmask = flag_mask(op_q);
  assign fnew  = {alu_v, alu_res[WIDTH-1], alu_c, ~|alu_res};

  // Control FSM; cnt holds remaining extra iterations, so EXEC ends when it is 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      REQ_READY <= 1'b1;
      BUSY      <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RES   <= '0;
      RSP_ERR   <= 1'b0;
      FLAGS     <= 4'b0000;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      noop_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            op_q      <= REQ_OP;
            a_q       <= REQ_A;
            b_q       <= REQ_B;
            noop_q    <= is_shift(REQ_OP) && (REQ_SHAMT == 5'd0);
            cnt       <= (is_shift(REQ_OP) && (REQ_SHAMT != 5'd0)) ? REQ_SHAMT - 5'd1 : 5'd0;
            state     <= EXEC;
            REQ_READY <= 1'b0;
            BUSY      <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt == 5'd0) begin
            state     <= DONE;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= alu_err;
            RSP_RES   <= noop_q ? a_q : alu_res;
            if (!noop_q) begin
              FLAGS <= (FLAGS & ~fmask) | (fnew & fmask);
            end
          end else begin
            cnt <= cnt - 5'd1;
            a_q <= alu_res;
          end
        end
        DONE: begin
          if (RSP_READY) begin
            state     <= IDLE;
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          RSP_VALID <= 1'b0;
          REQ_READY <= 1'b1;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed table-driven bench for alu_ctrl with hand-computed expectations.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [4:0]  REQ_OP;
  logic [31:0] REQ_A;
  logic [31:0] REQ_B;
  logic [4:0]  REQ_SHAMT;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RES;
  logic        RSP_ERR;
  logic [3:0]  FLAGS;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  alu_ctrl #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_OP    (REQ_OP),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_SHAMT (REQ_SHAMT),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RES   (RSP_RES),
    .RSP_ERR   (RSP_ERR),
    .FLAGS     (FLAGS),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        err;
    logic [3:0]  flags;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [31:0] res, input logic err,
                              input logic [3:0] flags, input int lat, input int hold);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.err = err;
    v.flags = flags; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One command: drive at negedge, accept at the next posedge, count edges to RSP_VALID
  task automatic run(input string tag, input vec_t v);
    int lat;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_OP    = v.op;
    REQ_A     = v.a;
    REQ_B     = v.b;
    REQ_SHAMT = v.sh;
    chk({tag, "_req_ready_idle"}, 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    REQ_OP    = OP_ONES;
    REQ_A     = ~v.a;
    REQ_B     = v.b ^ 32'h5A5A_5A5A;
    REQ_SHAMT = ~v.sh;
    chk({tag, "_busy_exec"}, 32'(BUSY), 32'd1);
    chk({tag, "_req_ready_exec"}, 32'(REQ_READY), 32'd0);
    lat = 0;
    while (!RSP_VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      chk($sformatf("%s_busy_%0d", tag, lat), 32'(BUSY), 32'd1);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_res"}, RSP_RES, v.res);
    chk({tag, "_err"}, 32'(RSP_ERR), 32'(v.err));
    chk({tag, "_flags"}, 32'(FLAGS), 32'(v.flags));
    chk({tag, "_req_ready_done"}, 32'(REQ_READY), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge CLK); #1;
      chk($sformatf("%s_hold_res_%0d", tag, h), RSP_RES, v.res);
      chk($sformatf("%s_hold_valid_%0d", tag, h), 32'(RSP_VALID), 32'd1);
      chk($sformatf("%s_hold_rdy_%0d", tag, h), 32'(REQ_READY), 32'd0);
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    chk({tag, "_rsp_valid_after"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    chk({tag, "_req_ready_after"}, 32'(REQ_READY), 32'd1);
  endtask

  initial begin
    int lat;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = '0; REQ_A = '0; REQ_B = '0;
    REQ_SHAMT = '0; RSP_READY = 1'b0;

    // op, a, b, shamt, res, err, flags{O,S,C,Z}, latency, hold
    vt.push_back(mk(OP_ADD,      32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 4'b0011, 1, 0));
    vt.push_back(mk(OP_PASSB,    32'h12345678, 32'hCAFEF00D, 5'd0,  32'hCAFEF00D, 1'b0, 4'b0011, 1, 3));
    vt.push_back(mk(OP_LSL,      32'h00000001, 32'h00000000, 5'd4,  32'h00000010, 1'b0, 4'b0000, 4, 0));
    vt.push_back(mk(OP_ADD,      32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 4'b1100, 1, 0));
    vt.push_back(mk(OP_ASR,      32'h80000000, 32'h00000000, 5'd31, 32'hFFFFFFFF, 1'b0, 4'b1100, 31, 0));
    vt.push_back(mk(5'b00010,    32'h00000005, 32'h00000006, 5'd0,  32'h00000000, 1'b1, 4'b1100, 1, 0));
    vt.push_back(mk(OP_SUB,      32'h00000003, 32'h00000005, 5'd0,  32'hFFFFFFFE, 1'b0, 4'b0100, 1, 0));
    vt.push_back(mk(OP_SUB,      32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 4'b0011, 1, 0));
    vt.push_back(mk(OP_AND,      32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0, 4'b0010, 1, 0));
    vt.push_back(mk(OP_XOR,      32'hFFFF0000, 32'hFF00FF00, 5'd0,  32'h00FFFF00, 1'b0, 4'b0010, 1, 0));
    vt.push_back(mk(OP_NOR,      32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 4'b0110, 1, 0));
    vt.push_back(mk(OP_ZEROS,    32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h00000000, 1'b0, 4'b0111, 1, 0));
    vt.push_back(mk(OP_ONES,     32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 4'b0111, 1, 0));
    vt.push_back(mk(OP_LSL,      32'h0000ABCD, 32'h00000000, 5'd0,  32'h0000ABCD, 1'b0, 4'b0111, 1, 0));
    vt.push_back(mk(OP_LSL,      32'h80000001, 32'h00000000, 5'd1,  32'h00000002, 1'b0, 4'b0010, 1, 0));
    vt.push_back(mk(OP_DECA,     32'h00000000, 32'h0000FFFF, 5'd0,  32'hFFFFFFFF, 1'b0, 4'b0100, 1, 0));
    vt.push_back(mk(OP_INCA,     32'h7FFFFFFF, 32'h12345678, 5'd0,  32'h80000000, 1'b0, 4'b1100, 1, 0));
    vt.push_back(mk(OP_ADDINC,   32'h00000001, 32'h00000002, 5'd0,  32'h00000004, 1'b0, 4'b0000, 1, 0));
    vt.push_back(mk(OP_SUBDEC,   32'h00000005, 32'h00000002, 5'd0,  32'h00000002, 1'b0, 4'b0010, 1, 0));
    vt.push_back(mk(OP_NAND,     32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0, 4'b0011, 1, 0));
    vt.push_back(mk(OP_PASSNOTA, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 4'b0110, 1, 0));
    vt.push_back(mk(OP_ANDNOTB,  32'hFF00FF00, 32'hF0F0F0F0, 5'd0,  32'h0F000F00, 1'b0, 4'b0010, 1, 0));
    vt.push_back(mk(OP_ASR,      32'h40000000, 32'h00000000, 5'd2,  32'h10000000, 1'b0, 4'b0000, 2, 0));
    vt.push_back(mk(OP_ASR,      32'h00000003, 32'h00000000, 5'd1,  32'h00000001, 1'b0, 4'b0010, 1, 0));
    vt.push_back(mk(OP_OR,       32'h0000FFFF, 32'h00FF0000, 5'd0,  32'h00FFFFFF, 1'b0, 4'b0010, 1, 0));
    vt.push_back(mk(5'b01111,    32'h00000009, 32'h00000009, 5'd0,  32'h00000000, 1'b1, 4'b0010, 1, 0));

    // Reset state while RST is held
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_res",   RSP_RES, 32'd0);
    chk("rst_rsp_err",   32'(RSP_ERR), 32'd0);
    chk("rst_flags",     32'(FLAGS), 32'd0);
    chk("rst_busy",      32'(BUSY), 32'd0);
    chk("rst_req_ready", 32'(REQ_READY), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    foreach (vt[i]) run($sformatf("v%0d", i), vt[i]);

    // Reset in the 2nd EXEC cycle of an 8-step LSL discards it; flags (0010) are cleared
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = OP_LSL; REQ_A = 32'h1; REQ_B = '0; REQ_SHAMT = 5'd8;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("mid_busy_pre", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    chk("mid_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("mid_rsp_res",   RSP_RES, 32'd0);
    chk("mid_rsp_err",   32'(RSP_ERR), 32'd0);
    chk("mid_flags",     32'(FLAGS), 32'd0);
    chk("mid_busy",      32'(BUSY), 32'd0);
    chk("mid_req_ready", 32'(REQ_READY), 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    run("post_rst_add", mk(OP_ADD, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 4'b0000, 1, 0));

    // REQ_VALID held high with a different command through EXEC/DONE is not queued
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = OP_ADD; REQ_A = 32'h10; REQ_B = 32'h20; REQ_SHAMT = '0;
    @(posedge CLK); #1;
    REQ_OP = OP_SUB; REQ_A = 32'h1; REQ_B = 32'h1;
    lat = 0;
    while (!RSP_VALID && lat < 40) begin
      chk($sformatf("nq_req_ready_%0d", lat), 32'(REQ_READY), 32'd0);
      @(posedge CLK); #1;
      lat++;
    end
    chk("nq_latency", 32'(lat), 32'd1);
    chk("nq_res", RSP_RES, 32'h30);
    chk("nq_flags", 32'(FLAGS), 32'd0);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("nq_busy_idle", 32'(BUSY), 32'd0);
    chk("nq_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("nq_res_kept", RSP_RES, 32'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have ports in this order: CLK, RST, then the request ports, then the response ports.
REQ-002 CLK  in  1  single clock; all state changes occur on its rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 REQ_VALID  in  1  command present.
REQ-005 REQ_READY  out  1  controller accepts a command; high only in IDLE.
REQ-006 REQ_OP  in  5  ALU opcode.
REQ-007 REQ_A, REQ_B  in  32 each  operands.
REQ-008 REQ_SHAMT  in  5  shift count, used by LSL/ASR only.
REQ-009 RSP_VALID  out  1  result available.
REQ-010 RSP_READY  in  1  consumer takes the result.
REQ-011 RSP_RES  out  32  result.
REQ-012 RSP_ERR  out  1  opcode was undefined.
REQ-013 FLAGS  out  4  persistent {O,S,C,Z} register.
REQ-014 BUSY  out  1  high whenever state is not IDLE.
REQ-015 Parameter WIDTH, default 32: datapath width; only 32 is verified.

Function
REQ-016 SHALL implement the FSM states IDLE, EXEC, DONE.
REQ-017 Transitions:
- IDLE->EXEC on REQ_VALID&&REQ_READY.
- EXEC->DONE when the iteration count reaches 0.
- DONE->IDLE on RSP_VALID&&RSP_READY.
REQ-018 On accept, SHALL latch OP, A, B, SHAMT; later input changes SHALL be ignored.
REQ-019 Non-shift ops: exactly one EXEC cycle. If the handshake is at edge k, RSP_VALID SHALL rise after edge k+1.
REQ-020 LSL/ASR with SHAMT=N>0: N EXEC cycles, the ALU result fed back as A each cycle; RSP_VALID SHALL rise after edge k+N.
REQ-021 LSL/ASR with SHAMT=0: one EXEC cycle; RSP_RES=A, FLAGS unchanged.
REQ-022 Shift C flag SHALL be taken from the final iteration only.
REQ-023 Undefined opcodes (00010, 00111, 01010-01111): one EXEC cycle; RSP_RES=0, RSP_ERR=1, FLAGS unchanged.
REQ-024 FLAGS SHALL be updated only at the EXEC->DONE edge, per-bit masked by op class:
- ADD/ADDINC/INCA/SUBDEC/SUB/DECA: O S C Z.
- LSL/ASR: S C Z.
- ZEROS: Z only.
- AND/ANDNOTA/ANDNOTB/PASSA/XOR/OR/NAND/XNOR/PASSNOTA/ORNOTA/PASSNOTB/ORNOTB/NOR: S Z.
- PASSB/ONES: none.
REQ-025 In DONE, RSP_RES, RSP_ERR and RSP_VALID SHALL hold stable until RSP_READY is sampled high.
REQ-026 Back-to-back commands: REQ_READY SHALL be low in DONE. A new accept is possible at the earliest one cycle after the response handshake.
REQ-027 REQ_VALID during EXEC/DONE SHALL be ignored and not queued.

Reset
REQ-028 RST high SHALL immediately force:
- State IDLE.
- REQ_READY=1 (once RST is low).
- RSP_VALID=0, RSP_RES=0, RSP_ERR=0.
- FLAGS=4'b0000, BUSY=0.
- Iteration counter=0.
REQ-029 Reset mid-EXEC or mid-DONE SHALL discard the command without updating FLAGS.

Structure
REQ-030 Opcode constants (24 codes), per-opcode flag-mask table and FSM state encoding SHALL live in shared package alu_pkg.
REQ-031 SHALL instantiate the existing alu as sub-module u_alu; there are no other sub-modules.
REQ-032 Operand/shift registers, counter, FSM and flag register SHALL reside in alu_ctrl.

Verification
REQ-033 ADD A=FFFFFFFF B=00000001 -> RSP_RES=00000000, FLAGS O=0 S=0 C=1 Z=1, RSP_VALID after edge k+1.
REQ-034 LSL A=00000001 SHAMT=4 -> RSP_RES=00000010, RSP_VALID after edge k+4, BUSY high for 4 cycles plus DONE.
REQ-035 ASR A=80000000 SHAMT=31 -> RSP_RES=FFFFFFFF, S=1, Z=0; O unchanged from its prior value.
REQ-036 PASSB after the ADD case -> RSP_RES=B, FLAGS still 4'b0011; RSP_READY low 3 cycles -> RSP_RES stable, REQ_READY low.
REQ-037 Opcode 5'b00010 -> RSP_ERR=1, RSP_RES=0, FLAGS unchanged.
REQ-038 RST asserted in the 2nd cycle of an LSL SHAMT=8 -> all outputs at reset values; next ADD 1+2 completes with RSP_RES=3, FLAGS=0000.
